dco_period_meter: RTL
=====================

Name: dco_period_meter

Overview:
Downstream measurement stage for the DCO output: samples `dco_in`, which is generated in the same `clk` domain, and counts `clk` cycles across 2^GATE_LOG2 consecutive DCO periods. It reports the raw sum and the average period in `clk` cycles. It flags dead oscillators (timeout) and counter saturation (overflow). The results feed the code-selection / calibration logic that drives the DCO code.

Parameters:
- GATE_LOG2, 4, log2 of the number of DCO periods per measurement window (legal range 0..8).
- CNT_W, 16, width of the cycle accumulator and `period_sum`.
- TIMEOUT, 1023, maximum `clk` cycles allowed without a `dco_in` rising edge while armed or measuring.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- ena  in  1  global enable; low freezes FSM and counters.
- dco_in  in  1  DCO output, `clk`-domain signal.
- start  in  1  single-cycle request to begin a measurement.
- continuous  in  1  restart automatically after each completed measurement.
- busy  out  1  high in ARM, MEASURE and DONE.
- meas_valid  out  1  one-cycle pulse when results update.
- period_sum  out  CNT_W  `clk` cycles spanning the window.
- period_avg  out  8  period_sum >> GATE_LOG2, saturated to 255.
- overflow  out  1  sticky; the accumulator saturated during the last measurement.
- timeout  out  1  sticky; the last measurement was aborted for lack of edges.

Behaviour:
- Reset (rst_n low at a `clk` edge):
  - FSM goes to IDLE.
  - All counters clear; `dco_q` clears.
  - Every output is 0: busy, meas_valid, period_sum, period_avg, overflow, timeout.
  - This applies mid-measurement as well; no partial result is published.
- Edge detect:
  - `dco_q` registers `dco_in` every cycle, independent of `ena`.
  - rise = dco_in & ~dco_q.
- ena low:
  - State, cycle/edge/gap counters and outputs hold.
  - Rising edges in these cycles are lost.
  - A meas_valid pulse is never stretched; it drops.
- FSM:
  - IDLE: when start is high → ARM; clear overflow and timeout.
  - ARM: on rise → MEASURE; cyc_cnt=0, edge_cnt=0, gap_cnt=0.
  - MEASURE, every cycle:
    - cyc_cnt increments, saturating at all-ones; saturation sets overflow.
    - gap_cnt increments.
  - MEASURE, on rise:
    - edge_cnt increments and gap_cnt clears.
    - When the new edge_cnt equals 2^GATE_LOG2: period_sum = cyc_cnt+1 (saturated), period_avg is updated, go to DONE.
  - DONE: meas_valid=1 for exactly this cycle. Then → ARM if continuous is high (overflow/timeout cleared), else → IDLE.
  - ARM/MEASURE timeout: if gap_cnt reaches TIMEOUT (gap_cnt also counts in ARM from entry), then timeout=1, → IDLE, no meas_valid, period_sum/period_avg keep their previous values.
- Result semantics:
  - DCO period P cycles → period_sum = 2^GATE_LOG2·P; period_avg = P.
  - The result is published 1 cycle after the final rising edge (DONE cycle).
- start handling:
  - start while busy is ignored.
  - start in the DONE cycle is ignored (continuous governs).
  - continuous is sampled only in DONE.
- period_sum, period_avg and overflow hold between measurements until the next DONE or reset. overflow/timeout clear only on leaving IDLE or DONE.
- Arithmetic:
  - Unsigned throughout.
  - period_avg = 255 if (period_sum >> GATE_LOG2) > 255.

Optional Feature:
Macro DCO_PERIOD_LOCK_DETECT_EN.
- Defined:
  - Adds inputs `target_period[7:0]` and `lock_tol[3:0]`, and output `locked`.
  - A 2-bit hit counter increments on each meas_valid where |period_avg − target_period| ≤ lock_tol, saturating at 3.
  - `locked` = 1 once 4 consecutive hits occur (counter at 3 plus a hit).
  - Any miss, timeout or overflow clears the counter and `locked`.
  - Reset value of `locked` is 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Period-8 DCO (toggle every 4 cycles), GATE_LOG2=4, start pulse → meas_valid 1 cycle after 17th rising edge; period_sum=128, period_avg=8, overflow=0, timeout=0.
- continuous=1, period 20 → back-to-back results period_sum=320/avg=20; busy stays high; one meas_valid per window; continuous dropped → FSM returns to IDLE after next DONE.
- dco_in held 0, start → after 1023 cycles in ARM, timeout=1, busy=0, no meas_valid, prior period_sum unchanged; next start clears timeout.
- CNT_W=8, period 100 → overflow=1, period_sum=255, period_avg=15, meas_valid still pulses.
- rst_n low for 1 cycle mid-MEASURE → next cycle all outputs 0, FSM IDLE; start after reset yields a correct fresh result.
- Lock detect (macro defined): target=8, tol=1, four period-8 measurements → locked=1 after 4th meas_valid; then a period-12 measurement → locked=0.

Source files
------------

// File: rtl/dco_period_meter.sv
// Measures the DCO period in clk cycles over 2^GATE_LOG2 DCO periods and reports the sum and the average.
// Optional lock detector (target_period/lock_tol/locked) is built when DCO_PERIOD_LOCK_DETECT_EN is defined.
module dco_period_meter #(
    parameter int unsigned GATE_LOG2 = 4,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             dco_in,
    input  logic             start,
    input  logic             continuous,
`ifdef DCO_PERIOD_LOCK_DETECT_EN
    input  logic [7:0]       target_period,
    input  logic [3:0]       lock_tol,
    output logic             locked,
`endif
    output logic             busy,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period_sum,
    output logic [7:0]       period_avg,
    output logic             overflow,
    output logic             timeout
);
    localparam int unsigned EDGE_W = 9;
    localparam int unsigned GAP_W  = $clog2(TIMEOUT + 1);
    localparam logic [EDGE_W-1:0] GATE_N   = EDGE_W'(2 ** GATE_LOG2);
    localparam logic [GAP_W-1:0]  GAP_LIM  = GAP_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  AVG_MAX  = CNT_W'(255);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

    state_t             state_q, state_d;
    logic               dco_q;
    logic               rise;
    logic [CNT_W-1:0]   cyc_q, cyc_d, cyc_inc;
    logic [EDGE_W-1:0]  edge_cnt_q, edge_cnt_d, edge_inc;
    logic [GAP_W-1:0]   gap_q, gap_d, gap_inc;
    logic [CNT_W-1:0]   sum_d, avg_full;
    logic [7:0]         avg_sat, avg_d;
    logic               ovf_d, tmo_d, valid_d, busy_d, tmo_evt, cyc_full;

    assign rise     = dco_in & ~dco_q;
    assign cyc_full = (cyc_q == '1);
    assign cyc_inc  = cyc_full ? cyc_q : cyc_q + CNT_W'(1);
    assign edge_inc = edge_cnt_q + EDGE_W'(1);
    assign gap_inc  = gap_q + GAP_W'(1);
    assign avg_full = cyc_inc >> GATE_LOG2;
    assign avg_sat  = (avg_full > AVG_MAX) ? 8'hFF : 8'(avg_full);

    // Edge-detect register runs regardless of ena
    always_ff @(posedge clk) begin
        if (!rst_n) dco_q <= 1'b0;
        else        dco_q <= dco_in;
    end

    // State and datapath registers; ena low freezes everything and drops the valid pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            edge_cnt_q <= '0;
            gap_q      <= '0;
            period_sum <= '0;
            period_avg <= '0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
            meas_valid <= 1'b0;
            busy       <= 1'b0;
        end else if (ena) begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            edge_cnt_q <= edge_cnt_d;
            gap_q      <= gap_d;
            period_sum <= sum_d;
            period_avg <= avg_d;
            overflow   <= ovf_d;
            timeout    <= tmo_d;
            meas_valid <= valid_d;
            busy       <= busy_d;
        end else begin
            meas_valid <= 1'b0;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        edge_cnt_d = edge_cnt_q;
        gap_d      = gap_q;
        sum_d      = period_sum;
        avg_d      = period_avg;
        ovf_d      = overflow;
        tmo_d      = timeout;
        valid_d    = 1'b0;
        tmo_evt    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARM;
                    ovf_d   = 1'b0;
                    tmo_d   = 1'b0;
                    gap_d   = '0;
                end
            end
            ARM: begin
                if (rise) begin
                    state_d    = MEASURE;
                    cyc_d      = '0;
                    edge_cnt_d = '0;
                    gap_d      = '0;
                end else if (gap_inc == GAP_LIM) begin
                    state_d = IDLE;
                    tmo_evt = 1'b1;
                end else begin
                    gap_d = gap_inc;
                end
            end
            MEASURE: begin
                cyc_d = cyc_inc;
                if (cyc_full) ovf_d = 1'b1;
                if (rise) begin
                    edge_cnt_d = edge_inc;
                    gap_d      = '0;
                    if (edge_inc == GATE_N) begin
                        sum_d   = cyc_inc;
                        avg_d   = avg_sat;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end
                end else if (gap_inc == GAP_LIM) begin
                    state_d = IDLE;
                    tmo_evt = 1'b1;
                end else begin
                    gap_d = gap_inc;
                end
            end
            DONE: begin
                if (continuous) begin
                    state_d = ARM;
                    ovf_d   = 1'b0;
                    tmo_d   = 1'b0;
                    gap_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (tmo_evt) tmo_d = 1'b1;
        busy_d = (state_d != IDLE);
    end

`ifdef DCO_PERIOD_LOCK_DETECT_EN
    logic [1:0] hit_q, hit_d;
    logic       locked_d, in_tol;
    logic [7:0] diff;

    // Counts consecutive in-tolerance results; the fourth consecutive hit declares lock
    always_comb begin
        diff     = (avg_sat >= target_period) ? avg_sat - target_period : target_period - avg_sat;
        in_tol   = (diff <= {4'b0000, lock_tol});
        hit_d    = hit_q;
        locked_d = locked;
        if (tmo_evt) begin
            hit_d    = 2'd0;
            locked_d = 1'b0;
        end else if (valid_d) begin
            if (ovf_d || !in_tol) begin
                hit_d    = 2'd0;
                locked_d = 1'b0;
            end else if (hit_q == 2'd3) begin
                locked_d = 1'b1;
            end else begin
                hit_d = hit_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_q  <= 2'd0;
            locked <= 1'b0;
        end else if (ena) begin
            hit_q  <= hit_d;
            locked <= locked_d;
        end
    end
`else
    // Lock detector not built in this configuration.
`endif

endmodule
